// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
//   PS2_PFX_EXT / PS2_PFX_BRK : extended and break prefix bytes
//   ps2_rx_state_e            : frame deserialiser states
//   ps2_evt_t                 : one folded key event {ext, rel, code}
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead FIFO of PS/2 key events.
//   clk_i, rst_i  : system clock, asynchronous active-high reset
//   push_i        : write push_data_i (dropped when full unless popping too)
//   pop_i         : consume the head entry (ignored when empty)
//   head_o        : head entry, all zero when empty
//   valid_o       : FIFO non-empty
//   count_o       : occupancy
//   overflow_o    : one-cycle pulse when a push was dropped
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  ps2_evt_t   push_data_i,
  input  logic       pop_i,
  output ps2_evt_t   head_o,
  output logic       valid_o,
  output logic [AW:0] count_o,
  output logic       overflow_o
);

  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull = (AW + 1)'(FIFO_DEPTH);

  ps2_evt_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q;
  logic            overflow_q;
  logic            full, empty, do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntFull);
    do_pop  = pop_i & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    do_push = push_i & (~full | do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i & ~do_push;
      // Power-of-two depth: pointers wrap by natural overflow.
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o     = empty ? '0 : mem_q[rptr_q];
  assign valid_o    = ~empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver in the system clock domain.
//   clk, rst          : system clock, asynchronous active-high reset
//   kbdclk, kbddat    : raw PS/2 lines (asynchronous)
//   key_code/_release/_extended : head event fields, zero when empty
//   key_valid, key_ready        : event handshake
//   fifo_count        : event FIFO occupancy
//   parity_err, frame_err, overflow : one-cycle error pulses
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter bit          CHECK_PARITY   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          kbdclk,
  input  logic                          kbddat,
  output logic [7:0]                    key_code,
  output logic                          key_release,
  output logic                          key_extended,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FiltOne  = FW'(1);
  localparam logic [FW-1:0] FiltLast = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TmoOne   = TW'(1);
  localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYCLES - 1);

  // Synchronisers and clock deglitch filter
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_s, dat_s;
  logic                   filt_q, filt_d, filt_flip, fall;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  always_comb begin
    filt_flip  = (clk_s != filt_q) && (filt_cnt_q == FiltLast);
    filt_cnt_d = ((clk_s != filt_q) && !filt_flip) ? filt_cnt_q + FiltOne : '0;
    filt_d     = filt_q ^ filt_flip;
    // The edge is acted on in the cycle the filter commits to the new low level.
    fall       = filt_q & filt_flip;
  end

  // Frame deserialiser
  ps2_rx_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout;
  logic          acc_q, acc_d;
  logic [7:0]    byte_q;
  logic          perr_q, perr_d, ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    acc_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (fall)                   tmo_d = TmoOne;
    else if (state_q != StIdle) tmo_d = tmo_q + TmoOne;
    else                        tmo_d = '0;
    timeout = (state_q != StIdle) && !fall && (tmo_q == TmoLast);

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          if (!dat_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          if (CHECK_PARITY && !ps2_parity_ok(shift_q, par_q)) perr_d = 1'b1;
          else if (!dat_s)                                      ferr_d = 1'b1;
          else                                                  acc_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d = StIdle;
      ferr_d  = 1'b1;
      tmo_d   = '0;
    end
  end

  // Prefix folding, one cycle after a byte is accepted
  logic     ext_q, ext_d, rel_q, rel_d;
  logic     push;
  ps2_evt_t push_data;

  always_comb begin
    ext_d          = ext_q;
    rel_d          = rel_q;
    push           = 1'b0;
    push_data.ext  = ext_q;
    push_data.rel  = rel_q;
    push_data.code = byte_q;
    if (perr_q || ferr_q) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (acc_q) begin
      if (byte_q == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_PFX_BRK) begin
        rel_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      acc_q      <= 1'b0;
      byte_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kbdclk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kbddat};
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      if (acc_d) byte_q <= shift_q;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
    end
  end

  ps2_evt_t head;

  ps2_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (key_ready),
    .head_o      (head),
    .valid_o     (key_valid),
    .count_o     (fifo_count),
    .overflow_o  (overflow)
  );

  assign key_code     = head.code;
  assign key_release  = head.rel;
  assign key_extended = head.ext;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Randomised scoreboard bench for ps2_scan_rx. Two instances share the PS/2 lines:
// index 0 checks parity, index 1 ignores it.
module tb_ps2_scan_rx;
  import ps2_pkg::*;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned FILT  = 4;
  localparam int unsigned TMO   = 5000;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HALF  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbdclk = 1'b1;
  logic       kbddat = 1'b1;
  logic       rdy  [2];
  logic [7:0] kc   [2];
  logic       krel [2];
  logic       kext [2];
  logic       kval [2];
  logic [3:0] cnt  [2];
  logic       perr [2];
  logic       ferr [2];
  logic       ovf  [2];

  ps2_scan_rx #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddat(kbddat),
    .key_code(kc[0]), .key_release(krel[0]), .key_extended(kext[0]),
    .key_valid(kval[0]), .key_ready(rdy[0]), .fifo_count(cnt[0]),
    .parity_err(perr[0]), .frame_err(ferr[0]), .overflow(ovf[0])
  );

  ps2_scan_rx #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddat(kbddat),
    .key_code(kc[1]), .key_release(krel[1]), .key_extended(kext[1]),
    .key_valid(kval[1]), .key_ready(rdy[1]), .fifo_count(cnt[1]),
    .parity_err(perr[1]), .frame_err(ferr[1]), .overflow(ovf[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ps2_evt_t expq0[$];
  ps2_evt_t expq1[$];
  bit m_ext [2];
  bit m_rel [2];
  int e_perr[2], e_ferr[2], e_ovf[2];
  int o_perr[2], o_ferr[2], o_ovf[2];
  int fall_cyc = 0;
  int val_lat  = -1;
  int ferr_lat = -1;
  bit kval0_prev = 1'b0;
  bit ferr0_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic clear_flags(input int i);
    m_ext[i] = 1'b0;
    m_rel[i] = 1'b0;
  endtask

  // What a complete frame should produce in each instance.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_evt_t ev;
    for (int i = 0; i < 2; i++) begin
      if (i == 0 && bad_par) begin
        e_perr[i]++;
        clear_flags(i);
      end else if (bad_stop) begin
        e_ferr[i]++;
        clear_flags(i);
      end else if (b == 8'hE0) begin
        m_ext[i] = 1'b1;
      end else if (b == 8'hF0) begin
        m_rel[i] = 1'b1;
      end else begin
        ev.ext  = m_ext[i];
        ev.rel  = m_rel[i];
        ev.code = b;
        clear_flags(i);
        if (i == 1) expq1.push_back(ev);
        else if (!rdy[0] && expq0.size() >= DEPTH) e_ovf[0]++;
        else expq0.push_back(ev);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame (or its first nbits), optionally with a short clock glitch mid-frame.
  task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0,
                      input int nbits = 11, input bit glitch = 1'b0);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (nbits == 11) model_frame(b, bad_par, bad_stop);
    for (int i = 0; i < nbits; i++) begin
      kbddat = bits[i];
      wait_cyc(HALF);
      if (glitch && i == 4) begin
        kbdclk = 1'b0;
        wait_cyc(2);
        kbdclk = 1'b1;
        wait_cyc(HALF);
      end
      kbdclk   = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HALF);
      kbdclk = 1'b1;
    end
    wait_cyc(HALF);
    kbddat = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expq0.size() != 0 || expq1.size() != 0) && n < 3000) begin
      wait_cyc(1);
      n++;
    end
    wait_cyc(10);
    chk({name, "_pending"}, expq0.size() + expq1.size(), 0);
    chk({name, "_count0"}, int'(cnt[0]), 0);
  endtask

  task automatic checkpoint(input string name);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_perr%0d", name, i), o_perr[i], e_perr[i]);
      chk($sformatf("%s_ferr%0d", name, i), o_ferr[i], e_ferr[i]);
      chk($sformatf("%s_ovf%0d", name, i), o_ovf[i], e_ovf[i]);
    end
  endtask

  task automatic check_event(input int i, input ps2_evt_t exp);
    chk($sformatf("evt%0d_code", i), int'(kc[i]), int'(exp.code));
    chk($sformatf("evt%0d_rel", i), int'(krel[i]), int'(exp.rel));
    chk($sformatf("evt%0d_ext", i), int'(kext[i]), int'(exp.ext));
  endtask

  // Monitor: pulses counted and handshakes scored away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (perr[i]) o_perr[i]++;
        if (ferr[i]) o_ferr[i]++;
        if (ovf[i])  o_ovf[i]++;
        if (kval[i] && rdy[i]) begin
          if (i == 0 && expq0.size() == 0 || i == 1 && expq1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_evt%0d: got code %0h expected no event", i, kc[i]);
          end else if (i == 0) begin
            check_event(0, expq0.pop_front());
          end else begin
            check_event(1, expq1.pop_front());
          end
        end
      end
      if (kval[0] && !kval0_prev) val_lat = cyc - fall_cyc;
      if (ferr[0] && !ferr0_prev) ferr_lat = cyc - fall_cyc;
      kval0_prev = kval[0];
      ferr0_prev = ferr[0];
    end
  end

  initial begin
    #(900_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int r;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    rst    = 1'b1;
    wait_cyc(3);
    chk("rst_valid", int'(kval[0]), 0);
    chk("rst_code", int'(kc[0]), 0);
    chk("rst_count", int'(cnt[0]), 0);
    chk("rst_errs", int'({perr[0], ferr[0], ovf[0]}), 0);
    rst = 1'b0;
    wait_cyc(5);

    // Plain make code and push latency after the stop edge.
    val_lat = -1;
    send(8'h2B);
    wait_cyc(20);
    chk_range("lat_2b", val_lat, SYNC + FILT, SYNC + FILT + 3);

    // Prefix folding.
    send(8'hF0); send(8'h2B);
    send(8'hE0); send(8'hF0); send(8'h75); send(8'h1C);
    drain("prefix");

    // Parity fault: dropped by instance 0, accepted by instance 1.
    send(8'h2B, 1'b1);
    drain("parity");
    checkpoint("parity");

    // Timeout after five bits, with a pending extended prefix that must be cleared.
    send(8'hE0);
    ferr_lat = -1;
    send(8'h1C, 1'b0, 1'b0, 5);
    for (int i = 0; i < 2; i++) begin
      e_ferr[i]++;
      clear_flags(i);
    end
    wait_cyc(TMO + 40);
    chk_range("tmo_lat", ferr_lat, TMO, TMO + SYNC + FILT + 4);
    send(8'h1C);
    drain("timeout");

    // Short glitches, mid-frame and while idle, must not register as edges.
    send(8'h3A, 1'b0, 1'b0, 11, 1'b1);
    kbdclk = 1'b0;
    wait_cyc(2);
    kbdclk = 1'b1;
    wait_cyc(30);
    drain("glitch");
    checkpoint("glitch");

    // Random traffic with prefixes and occasional parity/stop faults.
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else             b = 8'($urandom_range(1, 8'hDF));
      send(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end
    drain("random");
    checkpoint("random");

    // Overflow: consumer stalled, one event beyond capacity.
    rdy[0] = 1'b0;
    for (int n = 0; n < DEPTH + 1; n++) send(8'($urandom_range(1, 8'hDF)));
    wait_cyc(20);
    chk("ovf_count", int'(cnt[0]), DEPTH);
    rdy[0] = 1'b1;
    drain("overflow");
    checkpoint("overflow");

    // Reset mid-frame with an event still buffered.
    rdy[0] = 1'b0;
    send(8'h4D);
    send(8'h55, 1'b0, 1'b0, 5);
    rst = 1'b1;
    wait_cyc(2);
    chk("midrst_valid", int'(kval[0]), 0);
    chk("midrst_count", int'(cnt[0]), 0);
    chk("midrst_code", int'(kc[0]), 0);
    expq0.delete();
    for (int i = 0; i < 2; i++) clear_flags(i);
    rst    = 1'b0;
    rdy[0] = 1'b1;
    wait_cyc(10);
    send(8'h1C);
    drain("post_rst");
    checkpoint("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It synchronises and deglitches the raw keyboard clock and data lines and deframes 11-bit frames with start, parity and stop checking. It folds the E0 (extended) and F0 (break) prefixes into one key event per key action. Events are buffered in a FIFO behind a valid/ready handshake, replacing the earlier direct-on-kbdclk decoder that feeds the key-mapping logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on kbdclk and kbddat (min 2)
FILTER_LEN, 4, consecutive equal samples before the filtered kbdclk level changes
TIMEOUT_CYCLES, 5000, idle clk cycles allowed between falling edges inside a frame
FIFO_DEPTH, 8, event FIFO entries (power of two, min 2)
CHECK_PARITY, 1, 1 = drop frames with bad odd parity; 0 = ignore the parity bit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
kbdclk  in  1  raw PS/2 clock, asynchronous to clk
kbddat  in  1  raw PS/2 data, asynchronous to clk
key_code  out  8  scancode of the head event, without prefixes
key_release  out  1  head event is a break (F0 seen)
key_extended  out  1  head event is extended (E0 seen)
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts the head event when key_valid & key_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
parity_err  out  1  one-cycle pulse on a parity failure
frame_err  out  1  one-cycle pulse on bad start, bad stop or timeout
overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM IDLE; FIFO empty; prefix flags cleared; filter and synchroniser flops forced to 1 (bus idle high).
- Filter: filtered kbdclk toggles only after FILTER_LEN consecutive synchronised samples differ from the current level. A falling edge is a 1->0 change of the filtered level. Data is sampled from synchronised kbddat in that same cycle.
- FSM:
  - IDLE: on a falling edge with data=0, go to DATA and clear the bit counter. If data=1 at the falling edge, raise frame_err and stay in IDLE.
  - DATA: shift in 8 bits, LSB first. After the 8th, go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: if data=1 and (parity is odd over data+parity, or CHECK_PARITY=0), the byte is accepted. Otherwise raise parity_err (parity fault) or frame_err (stop=0). Parity takes precedence when both fail. Always return to IDLE.
- Timeout: in any state other than IDLE, a counter reloads on each falling edge. Reaching TIMEOUT_CYCLES forces IDLE, pulses frame_err and clears the prefix flags.
- Byte handling, one cycle after acceptance:
  - 0xE0 sets ext_flag.
  - 0xF0 sets rel_flag.
  - Any other byte pushes {ext_flag, rel_flag, byte} and clears both flags.
  - Any parity or frame error also clears both flags.
- Latency: the push lands on cycle S+1 (S = stop-sample cycle). key_valid is high from S+2 when the FIFO was empty. There is no bypass.
- FIFO is show-ahead: key_code, key_release and key_extended reflect the head while key_valid=1 and are 0 when the FIFO is empty.
- Full FIFO: a push with no pop in the same cycle is dropped and overflow pulses. A simultaneous push and pop when full succeeds, and the count is unchanged.
- Empty FIFO: key_ready is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame discards the partial frame. The first frame after release decodes normally.

Decomposition:
- Package ps2_pkg:
  - constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0
  - rx state enum {IDLE, DATA, PARITY, STOP}
  - packed struct ps2_evt_t {ext, rel, code[7:0]}
- Sub-module ps2_evt_fifo: synchronous show-ahead FIFO of ps2_evt_t, parameterised on FIFO_DEPTH, async active-high rst.
- The synchroniser, filter, FSM and prefix logic stay in ps2_scan_rx.

Test Plan:
- Frame for 0x2B (data bits 1,1,0,1,0,1,0,0; parity 1; stop 1), key_ready=1 -> one event: key_code=0x2B, key_release=0, key_extended=0; key_valid high exactly from S+2.
- Frames F0 then 2B -> a single event: 0x2B, key_release=1, key_extended=0. No event for the F0 byte.
- Frames E0, F0, 75 -> a single event: 0x75, key_extended=1, key_release=1. A following plain 0x1C frame gives an event with both flags 0.
- 0x2B with parity 0, CHECK_PARITY=1 -> parity_err pulses once, no event. Rerun with CHECK_PARITY=0 -> event 0x2B.
- Clocking stopped after 5 bits -> frame_err pulses TIMEOUT_CYCLES clk cycles after the last falling edge. A following good 0x1C frame gives a correct event. A 2-cycle glitch on kbdclk with FILTER_LEN=4 produces no bit.
- key_ready=0 with FIFO_DEPTH+1 events sent -> fifo_count=8, overflow pulses once, drain order matches send order for the first 8. Reset mid-frame -> outputs 0 and a clean next decode.
